game_controller: RTL and testbench

GAME_CONTROLLER -- requirements
Module: game_controller

---
 rtl/game_controller_pkg.sv | 27 ++
 rtl/game_controller_key_debouncer.sv | 60 ++++++
 rtl/game_controller.sv | 176 +++++++++++++++++
 tb/tb_game_controller.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_controller_pkg.sv
// Shared state encodings, colour codes and defaults
// for the pong match controller.
package game_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_POINT     = 3'd3,
    ST_PAUSED    = 3'd4,
    ST_GAME_OVER = 3'd5
  } state_e;

  localparam logic [2:0] COLOR_NONE = 3'b000;
  localparam logic [2:0] COLOR_P1   = 3'b001;
  localparam logic [2:0] COLOR_P2   = 3'b100;

  localparam int WIN_SCORE_DEF    = 5;
  localparam int SERVE_FRAMES_DEF = 60;

  function automatic logic [2:0] score_inc(
    input logic [2:0] s
  );
    return s + 3'd1;
  endfunction

endpackage

// File: rtl/game_controller_key_debouncer.sv
// Two-flop synchroniser plus stability counter for one
// active-low key; emits a single pulse per accepted press.
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB = DW'(DEBOUNCE_CYCLES);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic [DW-1:0] cnt_inc;

  assign cnt_inc = cnt_q + DW'(1);

  // Counter only runs while the synced level disagrees
  // with the accepted level; any agreement restarts it.
  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_inc == DB) begin
        level_d = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/game_controller.sv
// Match FSM for pong: serve timing, scoring, pause
// and game-over handling with debounced keys.
import game_controller_pkg::*;

module game_controller #(
  parameter int WIN_SCORE       = WIN_SCORE_DEF,
  parameter int SERVE_FRAMES    = SERVE_FRAMES_DEF,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       CLOCK_25,
  input  logic       RESET_N,
  input  logic       frame_tick,
  input  logic       key_start_n,
  input  logic       key_pause_n,
  input  logic       miss_p1,
  input  logic       miss_p2,
  output logic       run,
  output logic       paddle_en,
  output logic       ball_reset,
  output logic       serve_left,
  output logic [2:0] score_1,
  output logic [2:0] score_2,
  output logic [2:0] winner_color,
  output logic [2:0] state
);

  localparam int CW = $clog2(SERVE_FRAMES + 1);
  localparam logic [CW-1:0] SF = CW'(SERVE_FRAMES);
  localparam logic [2:0] WIN = 3'(WIN_SCORE);

  logic start_p, pause_p;

  logic [2:0]    state_q, state_d;
  logic [2:0]    saved_q, saved_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    s1_q, s1_d;
  logic [2:0]    s2_q, s2_d;
  logic          sl_q, sl_d;
  logic [2:0]    win_q, win_d;
  logic          run_q, run_d;
  logic          pad_q, pad_d;
  logic          br_q, br_d;
  logic [CW-1:0] cnt_inc;
  logic [2:0]    s1_inc, s2_inc;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_start (
    .clk  (CLOCK_25),
    .rst_n(RESET_N),
    .key_n(key_start_n),
    .press(start_p)
  );

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_pause (
    .clk  (CLOCK_25),
    .rst_n(RESET_N),
    .key_n(key_pause_n),
    .press(pause_p)
  );

  assign cnt_inc = cnt_q + CW'(1);
  assign s1_inc  = score_inc(s1_q);
  assign s2_inc  = score_inc(s2_q);

  always_ff @(posedge CLOCK_25) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      saved_q <= ST_IDLE;
      cnt_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      sl_q    <= 1'b0;
      win_q   <= COLOR_NONE;
      run_q   <= 1'b0;
      pad_q   <= 1'b0;
      br_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      cnt_q   <= cnt_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      sl_q    <= sl_d;
      win_q   <= win_d;
      run_q   <= run_d;
      pad_q   <= pad_d;
      br_q    <= br_d;
    end
  end

  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    cnt_d   = cnt_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    sl_d    = sl_q;
    win_d   = win_q;
    case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (start_p) begin
          state_d = ST_SERVE;
          cnt_d   = '0;
          s1_d    = '0;
          s2_d    = '0;
          win_d   = COLOR_NONE;
        end
      end
      ST_SERVE: begin
        if (pause_p) begin
          state_d = ST_PAUSED;
          saved_d = ST_SERVE;
        end else if (frame_tick) begin
          cnt_d = cnt_inc;
          if (cnt_inc == SF) state_d = ST_PLAY;
        end
      end
      // miss_p1 has priority; a miss swallows a pause
      ST_PLAY: begin
        if (miss_p1) begin
          s2_d = s2_inc;
          sl_d = 1'b1;
          if (s2_inc == WIN) begin
            state_d = ST_GAME_OVER;
            win_d   = COLOR_P2;
          end else begin
            state_d = ST_POINT;
          end
        end else if (miss_p2) begin
          s1_d = s1_inc;
          sl_d = 1'b0;
          if (s1_inc == WIN) begin
            state_d = ST_GAME_OVER;
            win_d   = COLOR_P1;
          end else begin
            state_d = ST_POINT;
          end
        end else if (pause_p) begin
          state_d = ST_PAUSED;
          saved_d = ST_PLAY;
        end
      end
      ST_POINT: begin
        state_d = ST_SERVE;
        cnt_d   = '0;
      end
      ST_PAUSED: begin
        if (start_p) state_d = saved_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    run_d = (state_d == ST_PLAY);
    pad_d = (state_d == ST_SERVE) ||
            (state_d == ST_PLAY);
    br_d  = (state_d == ST_POINT) ||
            (((state_q == ST_IDLE) ||
              (state_q == ST_GAME_OVER)) &&
             (state_d == ST_SERVE));
  end

  assign run          = run_q;
  assign paddle_en    = pad_q;
  assign ball_reset   = br_q;
  assign serve_left   = sl_q;
  assign score_1      = s1_q;
  assign score_2      = s2_q;
  assign winner_color = win_q;
  assign state        = state_q;

endmodule

// File: tb/tb_game_controller.sv
// Directed and random checks of game_controller against
// a transaction-level match model.
module tb_game_controller;

  localparam int DB = 4;
  localparam int SF = 3;
  localparam int WS = 2;

  logic CLOCK_25 = 1'b0;
  logic RESET_N = 1'b0;
  logic frame_tick = 1'b0;
  logic key_start_n = 1'b1;
  logic key_pause_n = 1'b1;
  logic miss_p1 = 1'b0;
  logic miss_p2 = 1'b0;
  logic run, paddle_en, ball_reset, serve_left;
  logic [2:0] score_1, score_2, winner_color, state;

  int checks = 0;
  int errors = 0;

  typedef enum int {
    M_IDLE, M_SERVE, M_PLAY, M_PAUSED, M_OVER
  } mode_t;

  mode_t m_mode, m_saved;
  int m_s1, m_s2, m_frames, m_left, m_winner;

  game_controller #(
    .WIN_SCORE(WS),
    .SERVE_FRAMES(SF),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .CLOCK_25    (CLOCK_25),
    .RESET_N     (RESET_N),
    .frame_tick  (frame_tick),
    .key_start_n (key_start_n),
    .key_pause_n (key_pause_n),
    .miss_p1     (miss_p1),
    .miss_p2     (miss_p2),
    .run         (run),
    .paddle_en   (paddle_en),
    .ball_reset  (ball_reset),
    .serve_left  (serve_left),
    .score_1     (score_1),
    .score_2     (score_2),
    .winner_color(winner_color),
    .state       (state)
  );

  always #5 CLOCK_25 = ~CLOCK_25;

  task automatic step();
    @(posedge CLOCK_25);
    #1;
  endtask

  task automatic chk(
    input string tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  function automatic int code(input mode_t m);
    case (m)
      M_IDLE:   return 0;
      M_SERVE:  return 1;
      M_PLAY:   return 2;
      M_PAUSED: return 4;
      default:  return 5;
    endcase
  endfunction

  function automatic int color(input int w);
    return (w == 1) ? 1 : (w == 2) ? 4 : 0;
  endfunction

  task automatic m_reset();
    m_mode = M_IDLE;
    m_saved = M_IDLE;
    m_s1 = 0;
    m_s2 = 0;
    m_frames = 0;
    m_left = 0;
    m_winner = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":state"}, 8'(state), 8'(code(m_mode)));
    chk({tag, ":run"}, 8'(run),
        8'(m_mode == M_PLAY));
    chk({tag, ":paddle"}, 8'(paddle_en),
        8'(m_mode == M_SERVE || m_mode == M_PLAY));
    chk({tag, ":s1"}, 8'(score_1), 8'(m_s1));
    chk({tag, ":s2"}, 8'(score_2), 8'(m_s2));
    chk({tag, ":win"}, 8'(winner_color),
        8'(color(m_winner)));
    chk({tag, ":left"}, 8'(serve_left), 8'(m_left));
  endtask

  task automatic do_tick(input string tag);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    if (m_mode == M_SERVE) begin
      m_frames++;
      if (m_frames == SF) m_mode = M_PLAY;
    end
    check_all(tag);
  endtask

  task automatic m_miss(
    input bit m1, input bit m2, output bit point
  );
    point = 1'b0;
    if (m_mode == M_PLAY && (m1 || m2)) begin
      if (m1) begin
        m_s2++;
        m_left = 1;
        if (m_s2 == WS) m_winner = 2;
      end else begin
        m_s1++;
        m_left = 0;
        if (m_s1 == WS) m_winner = 1;
      end
      if (m_winner != 0) begin
        m_mode = M_OVER;
      end else begin
        point = 1'b1;
        m_mode = M_SERVE;
        m_frames = 0;
      end
    end
  endtask

  task automatic after_miss(input string tag, input bit point);
    if (point) begin
      chk({tag, ":pt_state"}, 8'(state), 8'd3);
      chk({tag, ":pt_br"}, 8'(ball_reset), 8'd1);
      chk({tag, ":pt_run"}, 8'(run), 8'd0);
      step();
      chk({tag, ":br_end"}, 8'(ball_reset), 8'd0);
    end
    check_all(tag);
  endtask

  task automatic do_miss(
    input string tag, input bit m1, input bit m2
  );
    bit point;
    miss_p1 = m1;
    miss_p2 = m2;
    step();
    miss_p1 = 1'b0;
    miss_p2 = 1'b0;
    m_miss(m1, m2, point);
    after_miss(tag, point);
  endtask

  task automatic do_press(
    input string tag, input bit st, input bit pa
  );
    int br;
    int exp_br;
    bit pz;
    pz = pa && (m_mode == M_SERVE || m_mode == M_PLAY);
    exp_br = 0;
    if (pz) begin
      m_saved = m_mode;
      m_mode = M_PAUSED;
    end else if (st) begin
      if (m_mode == M_IDLE || m_mode == M_OVER) begin
        exp_br = 1;
        m_s1 = 0;
        m_s2 = 0;
        m_winner = 0;
        m_frames = 0;
        m_mode = M_SERVE;
      end else if (m_mode == M_PAUSED) begin
        m_mode = m_saved;
      end
    end
    br = 0;
    if (st) key_start_n = 1'b0;
    if (pa) key_pause_n = 1'b0;
    repeat (8) begin
      step();
      if (ball_reset) br++;
    end
    key_start_n = 1'b1;
    key_pause_n = 1'b1;
    repeat (8) begin
      step();
      if (ball_reset) br++;
    end
    chk({tag, ":br_pulses"}, 8'(br), 8'(exp_br));
    check_all(tag);
  endtask

  task automatic miss_with_pause(
    input string tag, input bit m1
  );
    bit point;
    key_pause_n = 1'b0;
    repeat (6) step();
    miss_p1 = m1;
    miss_p2 = !m1;
    step();
    miss_p1 = 1'b0;
    miss_p2 = 1'b0;
    m_miss(m1, !m1, point);
    after_miss(tag, point);
    key_pause_n = 1'b1;
    repeat (8) step();
    check_all({tag, ":settled"});
  endtask

  initial begin
    int r;
    m_reset();
    RESET_N = 1'b0;
    step();
    step();
    chk("rst:br", 8'(ball_reset), 8'd0);
    check_all("rst");
    RESET_N = 1'b1;
    step();
    check_all("rst_rel");

    key_start_n = 1'b0;
    repeat (3) step();
    key_start_n = 1'b1;
    step();
    key_start_n = 1'b0;
    repeat (3) step();
    key_start_n = 1'b1;
    repeat (10) begin
      step();
      chk("bounce:br", 8'(ball_reset), 8'd0);
    end
    check_all("bounce");

    do_press("start", 1'b1, 1'b0);
    repeat (SF) do_tick("serve");
    do_miss("miss_p2", 1'b0, 1'b1);

    repeat (2) do_tick("pre_pause");
    do_press("pause_srv", 1'b0, 1'b1);
    do_tick("tick_paused");
    do_press("resume_srv", 1'b1, 1'b0);
    do_tick("resume_tick");

    do_miss("both_miss", 1'b1, 1'b1);
    repeat (SF) do_tick("serve2");
    do_miss("win_p2", 1'b1, 1'b0);
    do_miss("miss_over", 1'b1, 1'b0);
    do_tick("tick_over");

    do_press("restart", 1'b1, 1'b0);
    repeat (SF) do_tick("serve3");
    do_press("start_pause", 1'b1, 1'b1);
    do_press("resume_play", 1'b1, 1'b0);
    miss_with_pause("miss_pause", 1'b0);

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 99);
      if (r < 45) do_tick("rnd_tick");
      else if (r < 60) do_miss("rnd_m1", 1'b1, 1'b0);
      else if (r < 75) do_miss("rnd_m2", 1'b0, 1'b1);
      else if (r < 80) do_miss("rnd_mb", 1'b1, 1'b1);
      else if (r < 90) do_press("rnd_st", 1'b1, 1'b0);
      else do_press("rnd_pa", 1'b0, 1'b1);
    end

    RESET_N = 1'b0;
    step();
    RESET_N = 1'b1;
    m_reset();
    step();
    do_press("s2_start", 1'b1, 1'b0);
    repeat (SF) do_tick("s2_serve");
    do_miss("s2_m1", 1'b1, 1'b0);
    repeat (SF) do_tick("s2_serve");
    do_miss("s2_m2", 1'b0, 1'b1);
    repeat (SF) do_tick("s2_serve");
    RESET_N = 1'b0;
    step();
    m_reset();
    chk("rst_play:br", 8'(ball_reset), 8'd0);
    check_all("rst_play");
    RESET_N = 1'b1;
    step();
    check_all("rst_play_rel");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
